// File: rtl/fsm_vec_pkg.sv
// fsm_vec_pkg: shared state encoding and default sizing for the vector sequencer
package fsm_vec_pkg;
   localparam int DEPTH_DEF = 16;
   localparam int FLUSH_DEF = 2;
   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RUN, ST_DRAIN} state_e;
endpackage

// File: rtl/both_fsm.sv
// both_fsm: two encodings of the same w/e counter FSM; out_diff flags any disagreement
module both_fsm (
   input  logic clk,
   input  logic rst_n,
   input  logic w,
   input  logic e,
   output logic out_diff
);
   logic [1:0] a_q;
   logic [2:0] b_q;
   // binary-encoded copy: e clears, w advances modulo 3
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) a_q <= '0;
      else a_q <= e ? 2'd0 : w ? ((a_q == 2'd2) ? 2'd0 : a_q + 2'd1) : a_q;
   // one-hot copy of the same machine
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) b_q <= 3'b001;
      else b_q <= e ? 3'b001 : w ? {b_q[1:0], b_q[2]} : b_q;
   assign out_diff = (a_q == 2'd2) ^ b_q[2];
endmodule

// File: rtl/fsm_vec_mem.sv
// fsm_vec_mem: DEPTH x 2 pattern register file, synchronous write, asynchronous read
module fsm_vec_mem
   import fsm_vec_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [1:0]               wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [1:0]               rdata_o
);
   logic [1:0] mem_q [DEPTH];
   // write port; contents are deliberately left unreset
   always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fsm_vec_seq.sv
// fsm_vec_seq: replays a stored {w,e} pattern into an FSM pair and scores out_diff per vector
module fsm_vec_seq
   import fsm_vec_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int FLUSH = FLUSH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [1:0]                 wr_data,
   input  logic [$clog2(DEPTH):0]     len,
   input  logic                       start,
   input  logic                       out_diff,
   output logic                       w,
   output logic                       e,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     mism_cnt,
   output logic                       fail_seen,
   output logic [$clog2(DEPTH)-1:0]   first_fail
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (AW > 4) ? AW : 4;
   localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW:0]   len_q, len_d, mism_q, mism_d;
   logic          w_q, e_q, done_q, tag_v_q, fail_q;
   logic          w_d, e_d, done_d, tag_v_d, fail_d;
   logic [AW-1:0] tag_idx_q, first_q, tag_idx_d, first_d;
   logic [1:0]    vec, vec_eff;
   logic          accept, hit, mem_we;
   assign accept = state_q == ST_IDLE && start && len != '0 && len <= LEN_MAX;
   assign hit    = tag_v_q && out_diff;
   assign mem_we = wr_en && state_q == ST_IDLE;
   fsm_vec_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (cnt_d[AW-1:0]),
      .rdata_o (vec)
   );
   // a write landing on the edge that starts RUN directly must be seen by that run
   assign vec_eff = (mem_we && wr_addr == cnt_d[AW-1:0]) ? wr_data : vec;
   // state, vector/flush counter and latched run length
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   // next state: cnt counts flush cycles in FLUSH and is the vector index in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            state_d = (FLUSH > 0) ? ST_FLUSH : ST_RUN;
            cnt_d   = '0;
            len_d   = len;
         end
         ST_FLUSH: begin
            state_d = (cnt_q == CW'(FLUSH - 1)) ? ST_RUN : ST_FLUSH;
            cnt_d   = (cnt_q == CW'(FLUSH - 1)) ? '0 : cnt_q + 1'b1;
         end
         ST_RUN: begin
            state_d = (cnt_q[AW-1:0] == AW'(len_q - 1'b1)) ? ST_DRAIN : ST_RUN;
            cnt_d   = (cnt_q[AW-1:0] == AW'(len_q - 1'b1)) ? '0 : cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   // outputs: registered stimulus, tag pipeline one cycle behind the vector, scoring
   always_comb begin
      {w_d, e_d} = (state_d == ST_RUN) ? vec_eff : 2'b00;
      done_d     = state_q == ST_DRAIN;
      tag_v_d    = state_q == ST_RUN;
      tag_idx_d  = cnt_q[AW-1:0];
      mism_d     = accept ? '0 : mism_q + {{AW{1'b0}}, hit};
      fail_d     = accept ? 1'b0 : fail_q | hit;
      first_d    = accept ? '0 : (hit && !fail_q) ? tag_idx_q : first_q;
   end
   // output and result registers, all cleared by reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_q       <= 1'b0;
         e_q       <= 1'b0;
         done_q    <= 1'b0;
         tag_v_q   <= 1'b0;
         tag_idx_q <= '0;
         mism_q    <= '0;
         fail_q    <= 1'b0;
         first_q   <= '0;
      end else begin
         w_q       <= w_d;
         e_q       <= e_d;
         done_q    <= done_d;
         tag_v_q   <= tag_v_d;
         tag_idx_q <= tag_idx_d;
         mism_q    <= mism_d;
         fail_q    <= fail_d;
         first_q   <= first_d;
      end
   assign w          = w_q;
   assign e          = e_q;
   assign busy       = state_q != ST_IDLE;
   assign done       = done_q;
   assign mism_cnt   = mism_q;
   assign fail_seen  = fail_q;
   assign first_fail = first_q;
endmodule

// File: tb/tb_fsm_vec_seq.sv
// tb_fsm_vec_seq: directed and randomized runs of fsm_vec_seq against a cycle-level reference model
module tb_fsm_vec_seq;
   localparam int DEPTH = 16;
   localparam int FLUSH = 2;
   logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, inj = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [1:0] wr_data = '0;
   logic [4:0] len = '0;
   logic       out_diff, pair_diff, w, e, busy, done, fail_seen;
   logic [4:0] mism_cnt;
   logic [3:0] first_fail;
   logic [1:0] pat [DEPTH];
   int         total = 0, bad = 0;
   int         last_m = 0, last_f = 0, last_first = 0;

   always #5 clk = ~clk;
   assign out_diff = pair_diff | inj;

   fsm_vec_seq #(.DEPTH(DEPTH), .FLUSH(FLUSH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .start(start), .out_diff(out_diff), .w(w), .e(e), .busy(busy),
      .done(done), .mism_cnt(mism_cnt), .fail_seen(fail_seen), .first_fail(first_fail)
   );
   both_fsm u_pair (.clk(clk), .rst_n(rst_n), .w(w), .e(e), .out_diff(pair_diff));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_results(input string tag, input int m, input int f, input int first);
      chk({tag, "_mism"}, 32'(mism_cnt), 32'(m));
      chk({tag, "_fail"}, 32'(fail_seen), 32'(f));
      chk({tag, "_first"}, 32'(first_fail), 32'(first));
   endtask

   task automatic write_vec(input logic [3:0] a, input logic [1:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      pat[a] = d;
   endtask

   task automatic do_run(input int ln, input logic [15:0] mask, input bit hold, input bit junk, input int rst_c);
      int m = 0, ff = 0, fs = 0, last_c;
      logic [3:0] a;
      for (int i = ln - 1; i >= 0; i--) if (mask[4'(i)]) begin m++; ff = i; fs = 1; end
      last_c = FLUSH + ln + 2;
      start = 1'b1;
      len = 5'(ln);
      @(posedge clk);
      for (int c = 1; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 1) begin
            wr_en = 1'b0;
            if (!hold) start = 1'b0;
            chk_results("clear", 0, 0, 0);
         end
         if (junk && c == 3) begin
            a = 4'($urandom_range(0, DEPTH - 1));
            wr_en = 1'b1;
            wr_addr = a;
            wr_data = ~pat[a];
         end
         if (junk && c == 4) wr_en = 1'b0;
         chk("we", 32'({w, e}), (c > FLUSH && c <= FLUSH + ln) ? 32'(pat[4'(c - FLUSH - 1)]) : 32'(0));
         chk("busy", 32'(busy), 32'(c < last_c));
         chk("done", 32'(done), 32'(c == last_c));
         inj = (c >= FLUSH + 2 && c < FLUSH + 2 + ln) ? mask[4'(c - FLUSH - 2)] : 1'b0;
         if (c == rst_c) begin
            rst_n = 1'b0;
            start = 1'b0;
            inj = 1'b0;
            wr_en = 1'b0;
            #1;
            chk("rst_we", 32'({w, e}), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk_results("rst", 0, 0, 0);
            last_m = 0; last_f = 0; last_first = 0;
            return;
         end
      end
      chk_results("run", m, fs, ff);
      last_m = m; last_f = fs; last_first = ff;
   endtask

   initial begin
      logic [1:0] dir [6];
      int bad_lens [2];
      dir = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      bad_lens = '{0, 17};
      repeat (2) @(negedge clk);
      chk("reset_we", 32'({w, e}), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk_results("reset", 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      for (int i = 0; i < DEPTH; i++) write_vec(4'(i), 2'($urandom));
      for (int i = 0; i < 6; i++) write_vec(4'(i), dir[i]);
      do_run(6, 16'h0000, 1'b0, 1'b0, 0);
      do_run(6, 16'h0014, 1'b0, 1'b0, 0);
      for (int j = 0; j < 2; j++) begin
         start = 1'b1;
         len = 5'(bad_lens[j]);
         repeat (3) begin
            @(negedge clk);
            chk("badlen_busy", 32'(busy), 0);
            chk("badlen_done", 32'(done), 0);
            chk_results("hold", last_m, last_f, last_first);
         end
         start = 1'b0;
      end
      do_run(16, 16'hFFFF, 1'b0, 1'b0, 0);
      do_run($urandom_range(1, DEPTH), 16'($urandom), 1'b1, 1'b0, 0);
      do_run($urandom_range(1, DEPTH), 16'($urandom), 1'b1, 1'b1, 0);
      do_run(16, 16'($urandom), 1'b0, 1'b0, 0);
      wr_en = 1'b1;
      wr_addr = 4'd0;
      wr_data = ~pat[0];
      pat[0] = ~pat[0];
      do_run(3, 16'h0006, 1'b0, 1'b0, 0);
      do_run(6, 16'h0001, 1'b0, 1'b0, 6);
      repeat (2) begin
         @(negedge clk);
         chk("inrst_busy", 32'(busy), 0);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_done", 32'(done), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end
      do_run(6, 16'h0022, 1'b0, 1'b0, 0);
      for (int r = 0; r < 6; r++) begin
         write_vec(4'($urandom_range(0, DEPTH - 1)), 2'($urandom));
         do_run($urandom_range(1, DEPTH), 16'($urandom), 1'b0, 1'b0, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fsm_vec_seq.md
FSM_VEC_SEQ -- requirements
Module: fsm_vec_seq

Interface
REQ-001 Parameter DEPTH, default 16, pattern memory depth in vectors; power of two, 2..64.
REQ-002 Parameter FLUSH, default 2, number of {w,e}=00 vectors driven before each pattern; range 0..15.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  pattern-memory write strobe.
REQ-006 wr_addr  input  log2(DEPTH)  write address.
REQ-007 wr_data  input  2  vector {w,e}; bit 1 is w.
REQ-008 len  input  log2(DEPTH)+1  vectors per run; legal range 1..DEPTH.
REQ-009 start  input  1  run request, level-sampled.
REQ-010 out_diff  input  1  mismatch flag from the checked FSM pair.
REQ-011 w  output  1  registered stimulus to the FSM pair.
REQ-012 e  output  1  registered stimulus to the FSM pair.
REQ-013 busy  output  1  high while a run is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 mism_cnt  output  log2(DEPTH)+1  mismatching vectors in the last run.
REQ-016 fail_seen  output  1  at least one mismatch in the last run.
REQ-017 first_fail  output  log2(DEPTH)  index of the lowest mismatching vector.

Function
REQ-018 States SHALL be IDLE, FLUSH, RUN and DRAIN; busy SHALL be high in every state except IDLE.
REQ-019 In IDLE, start=1 with 1<=len<=DEPTH SHALL latch len, clear mism_cnt, fail_seen and first_fail, and go to FLUSH (or to RUN if FLUSH=0).
REQ-020 start with len=0 or len>DEPTH SHALL be ignored; no busy, no done.
REQ-021 start while busy SHALL be ignored.
REQ-022 FLUSH SHALL drive w=e=0 for exactly FLUSH cycles, then go to RUN; flush vectors are never checked.
REQ-023 In RUN, vector index k SHALL be presented on w/e during the k-th RUN cycle, k=0..len-1; after k=len-1 the state SHALL go to DRAIN.
REQ-024 out_diff SHALL be sampled one cycle after vector k is presented and attributed to k, via a valid/index tag pipeline.
REQ-025 The last sample of a run SHALL be taken in DRAIN; DRAIN SHALL last one cycle with w=e=0, then return to IDLE.
REQ-026 Each sampled out_diff=1 SHALL increment mism_cnt; the maximum value is DEPTH, so no saturation is needed.
REQ-027 The first mismatch of a run SHALL load first_fail=k and set fail_seen; later mismatches SHALL leave first_fail unchanged.
REQ-028 done SHALL pulse high for one cycle on the cycle after DRAIN, coincident with busy=0.
REQ-029 Results SHALL hold until the next accepted start.
REQ-030 In IDLE, w=e=0.
REQ-031 Writes SHALL be accepted only in IDLE; writes while busy SHALL be dropped.
REQ-032 A write in the same cycle as an accepted start SHALL commit first and be used by that run.
REQ-033 If start is held high, a new run SHALL be accepted in the IDLE cycle that carries done (back-to-back runs).

Reset
REQ-034 rst_n low SHALL immediately force state IDLE and w=e=busy=done=mism_cnt=fail_seen=first_fail=0, including mid-run; the tag pipeline SHALL clear.
REQ-035 Pattern memory SHALL NOT be reset; contents are undefined until written.

Structure
REQ-036 Package fsm_vec_pkg SHALL hold the state enum typedef and the DEPTH/FLUSH defaults.
REQ-037 Pattern storage SHALL be sub-module fsm_vec_mem: DEPTH x 2 register file, synchronous write, asynchronous read.
REQ-038 The bench SHALL connect fsm_vec_seq w/e/out_diff to both_fsm.

Verification
REQ-039 Load 11,00,01,00,01,00, len=6, FLUSH=2, matched FSMs -> w/e show 00,00 then the six vectors in order; done exactly 10 cycles after the start edge; mism_cnt=0, fail_seen=0.
REQ-040 Same pattern, out_diff forced 1 when vectors 2 and 4 are attributed -> mism_cnt=2, first_fail=2, fail_seen=1.
REQ-041 len=0 start, then len=DEPTH with out_diff tied 1 -> first: no busy/done; second: mism_cnt=16, first_fail=0.
REQ-042 start held high for three runs -> three done pulses; results cleared at each accept; writes during busy do not change the pattern.
REQ-043 rst_n asserted during RUN vector 3 -> outputs 0 asynchronously; after release, no done until a new start; an accepted start works normally.
